cache_axi_rd_arbiter: RTL and testbench
=======================================

Name: cache_axi_rd_arbiter

Overview:
Two-requester read-burst arbiter sharing the single memory read channel between inst_cache (port 0) and data_cache (port 1). It accepts one burst request, registers address/length, and drives the master AR handshake. It then routes R beats to the granted cache until rlast and returns to idle. Data side has fixed priority, with a starvation guard that forces an instruction grant after a bounded run of data grants.

Parameters:
LEN_W, 4, width of burst length field; beats = len+1 (cached line of 8 words -> len 7; uncached -> len 0)
MAX_CONSEC_D, 4, max consecutive port-1 grants while port 0 is pending before port 0 is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s0_araddr  in  32  inst_cache burst start address
s0_arlen  in  LEN_W  inst_cache beats-1
s0_arvalid  in  1  inst_cache request valid
s0_arready  out  1  one-cycle accept pulse to inst_cache
s0_rdata  out  32  read data to inst_cache
s0_rvalid  out  1  beat valid to inst_cache
s0_rlast  out  1  last beat to inst_cache
s0_rready  in  1  inst_cache beat ready
s1_araddr, s1_arlen, s1_arvalid, s1_arready, s1_rdata, s1_rvalid, s1_rlast, s1_rready: same as port 0, for data_cache
m_araddr  out  32  burst address to memory
m_arlen  out  LEN_W  burst length to memory
m_arvalid  out  1  address valid
m_arready  in  1  memory address accept
m_rdata  in  32  memory read data
m_rvalid  in  1  memory beat valid
m_rlast  in  1  memory last beat
m_rready  out  1  beat ready to memory
grant_id  out  1  0=inst, 1=data; valid when busy=1
busy  out  1  1 in ADDR or DATA
len_err  out  1  one-cycle pulse on length/rlast mismatch

Behaviour:
- Reset (rst=1 at posedge): state IDLE; m_arvalid, m_rready, s*_arready, s*_rvalid, s*_rlast, busy, len_err = 0; m_araddr, m_arlen = 0; grant_id = 0; beat counter and consecutive-data counter = 0. Reset mid-burst abandons the burst immediately; memory shares rst.
- States: IDLE, ADDR, DATA.
- IDLE: if no arvalid, stay. Otherwise pick the winner:
  - Port 1 wins if s1_arvalid, unless s0_arvalid and consec_d == MAX_CONSEC_D, in which case port 0 wins.
  - Port 0 wins if only s0_arvalid.
- IDLE grant, same cycle: combinational winner s*_arready = 1 (only in IDLE, only the winner). At the posedge, latch araddr/arlen into m_araddr/m_arlen, set grant_id, clear beat counter, go to ADDR.
- Consecutive-data counter: increments on a port-1 grant when s0_arvalid=1 (saturating at MAX_CONSEC_D). Clears on a port-0 grant, or on a port-1 grant with s0_arvalid=0.
- Latency: m_arvalid is high in the cycle after arvalid is seen.
- ADDR: m_arvalid = 1 with m_araddr/m_arlen held stable until m_arready=1 at a posedge, then DATA. m_arvalid is never dropped before acceptance.
- DATA:
  - m_rready = granted s*_rready.
  - Granted s*_rdata = m_rdata, s*_rvalid = m_rvalid, s*_rlast = m_rlast, all combinational pass-through.
  - Non-granted port: rvalid = rlast = 0, rdata = 0.
  - Beat counter increments on each m_rvalid&&m_rready.
  - On a handshaked beat with m_rlast=1: go to IDLE. len_err pulses next cycle if counter != m_arlen.
  - On a handshaked beat with counter == m_arlen and m_rlast=0: len_err pulses; stay in DATA until rlast.
- Outside DATA: m_rready = 0, all s*_rvalid = 0.
- Back-to-back: at least one IDLE cycle between the rlast beat and the next m_arvalid. A request held during another's burst is served at the next IDLE.
- A requester must hold arvalid and arlen/araddr stable until it sees arready. The arbiter never accepts two requests at once.
- Simultaneous s0/s1 arvalid: exactly one arready pulse. The loser keeps arvalid high and is granted at the next IDLE (given the priority rule).
- No flush/abort: a granted burst always completes. The inst_cache must drain the burst after a pipeline flush.
- busy = (state != IDLE).

Test Plan:
- Reset during DATA of an 8-beat port-1 burst -> next cycle m_arvalid=0, m_rready=0, busy=0, s1_rvalid=0.
- s0 only, addr 0xBFC00000, len 7; m_arready 1 cycle later; 8 beats -> s0_arready pulse at cycle 0, m_arvalid at cycle 1 with addr 0xBFC00000, s0 gets 8 beats, s0_rlast on beat 8, s1_rvalid stays 0, len_err=0.
- s0 and s1 arvalid same cycle (0xBFC00040 / 0x80001000, len 7) -> s1 granted first (grant_id=1); s0 granted after s1's rlast plus one IDLE; m_araddr=0x80001000 then 0xBFC00040.
- s1 requests continuously and s0 pending, MAX_CONSEC_D=4 -> grant order 1,1,1,1,0,1.
- Uncached s1 len 0, memory returns 1 beat with rlast; then a second burst with len 3 where memory asserts rlast on beat 2 -> first: single beat, len_err=0; second: len_err pulses once, return to IDLE.
- s1_rready held low for 3 cycles mid-burst -> m_rready=0 for those cycles, beat counter frozen, no beat lost or duplicated.

Source files
------------

// File: rtl/cache_axi_rd_arbiter.sv
// Read-burst arbiter: inst_cache (port 0) and data_cache (port 1) share one
// memory read channel; data side has priority with an inst starvation guard.
module cache_axi_rd_arbiter #(
  parameter int LEN_W        = 4,
  parameter int MAX_CONSEC_D = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s0_araddr,
  input  logic [LEN_W-1:0] s0_arlen,
  input  logic             s0_arvalid,
  output logic             s0_arready,
  output logic [31:0]      s0_rdata,
  output logic             s0_rvalid,
  output logic             s0_rlast,
  input  logic             s0_rready,
  input  logic [31:0]      s1_araddr,
  input  logic [LEN_W-1:0] s1_arlen,
  input  logic             s1_arvalid,
  output logic             s1_arready,
  output logic [31:0]      s1_rdata,
  output logic             s1_rvalid,
  output logic             s1_rlast,
  input  logic             s1_rready,
  output logic [31:0]      m_araddr,
  output logic [LEN_W-1:0] m_arlen,
  output logic             m_arvalid,
  input  logic             m_arready,
  input  logic [31:0]      m_rdata,
  input  logic             m_rvalid,
  input  logic             m_rlast,
  output logic             m_rready,
  output logic             grant_id,
  output logic             busy,
  output logic             len_err
);

  localparam int CW = $clog2(MAX_CONSEC_D + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    consec_q, consec_d;
  logic             gnt_q, gnt_d;
  logic             err_q, err_d;

  logic pick0, pick1;
  logic sel_rready;
  logic in_data;
  logic beat;

  always_comb begin
    // Port 1 loses only when port 0 has waited out a full run of data grants.
    pick1 = s1_arvalid &&
            !(s0_arvalid && (consec_q == CW'(MAX_CONSEC_D)));
    pick0 = s0_arvalid && !pick1;
    in_data    = (state_q == DATA);
    sel_rready = gnt_q ? s1_rready : s0_rready;
    beat       = in_data && m_rvalid && sel_rready;

    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    consec_d = consec_q;
    gnt_d    = gnt_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick0 || pick1) begin
          addr_d  = pick1 ? s1_araddr : s0_araddr;
          len_d   = pick1 ? s1_arlen : s0_arlen;
          gnt_d   = pick1;
          cnt_d   = '0;
          state_d = ADDR;
          if (pick1 && s0_arvalid) begin
            if (consec_q != CW'(MAX_CONSEC_D))
              consec_d = consec_q + CW'(1);
          end else begin
            consec_d = '0;
          end
        end
      end
      ADDR: begin
        if (m_arready)
          state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (m_rlast) begin
            state_d = IDLE;
            err_d   = (cnt_q != len_q);
          end else if (cnt_q == len_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      consec_q <= '0;
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
    end
  end

  assign s0_arready = (state_q == IDLE) && pick0;
  assign s1_arready = (state_q == IDLE) && pick1;

  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arvalid = (state_q == ADDR);
  assign m_rready  = in_data && sel_rready;

  assign s0_rvalid = in_data && !gnt_q && m_rvalid;
  assign s0_rlast  = in_data && !gnt_q && m_rlast;
  assign s0_rdata  = (in_data && !gnt_q) ? m_rdata : 32'h0;
  assign s1_rvalid = in_data && gnt_q && m_rvalid;
  assign s1_rlast  = in_data && gnt_q && m_rlast;
  assign s1_rdata  = (in_data && gnt_q) ? m_rdata : 32'h0;

  assign grant_id = gnt_q;
  assign busy     = (state_q != IDLE);
  assign len_err  = err_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: request agents, a memory model and a
// scoreboard of expected beats and grant order.
module tb_cache_axi_rd_arbiter;

  localparam int LEN_W = 4;
  localparam int MAXC  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      s0_araddr, s1_araddr;
  logic [LEN_W-1:0] s0_arlen, s1_arlen;
  logic             s0_arvalid, s1_arvalid;
  logic             s0_arready, s1_arready;
  logic [31:0]      s0_rdata, s1_rdata;
  logic             s0_rvalid, s1_rvalid;
  logic             s0_rlast, s1_rlast;
  logic             s0_rready = 1'b1;
  logic             s1_rready = 1'b1;
  logic [31:0]      m_araddr;
  logic [LEN_W-1:0] m_arlen;
  logic             m_arvalid;
  logic             m_arready;
  logic [31:0]      m_rdata;
  logic             m_rvalid;
  logic             m_rlast;
  logic             m_rready;
  logic             grant_id, busy, len_err;

  cache_axi_rd_arbiter #(
    .LEN_W       (LEN_W),
    .MAX_CONSEC_D(MAXC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s0_araddr (s0_araddr),
    .s0_arlen  (s0_arlen),
    .s0_arvalid(s0_arvalid),
    .s0_arready(s0_arready),
    .s0_rdata  (s0_rdata),
    .s0_rvalid (s0_rvalid),
    .s0_rlast  (s0_rlast),
    .s0_rready (s0_rready),
    .s1_araddr (s1_araddr),
    .s1_arlen  (s1_arlen),
    .s1_arvalid(s1_arvalid),
    .s1_arready(s1_arready),
    .s1_rdata  (s1_rdata),
    .s1_rvalid (s1_rvalid),
    .s1_rlast  (s1_rlast),
    .s1_rready (s1_rready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready),
    .grant_id  (grant_id),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
  } req_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  req_t        rq0[$], rq1[$];
  beat_t       bq0[$], bq1[$];
  logic [31:0] aq[$];
  logic        gq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int short_last = -1;
  int lerr_cnt = 0;
  int beats0 = 0;
  int beats1 = 0;
  int cyc = 0;
  int last_rl = -100;
  logic prev_av = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input int p, input logic [31:0] a,
                     input logic [LEN_W-1:0] l, input int nb);
    req_t  r;
    beat_t e;
    int    n;
    n = (nb < 0) ? int'(l) + 1 : nb;
    r.addr = a;
    r.len  = l;
    if (p == 0) rq0.push_back(r);
    else rq1.push_back(r);
    for (int b = 0; b < n; b++) begin
      e.d = a + 32'(4 * b);
      e.l = (b == n - 1);
      if (p == 0) bq0.push_back(e);
      else bq1.push_back(e);
    end
  endtask

  task automatic expect_ar(input logic [31:0] a, input logic g);
    aq.push_back(a);
    gq.push_back(g);
  endtask

  // Request agent, port 0
  initial begin : agent0
    logic acc, rs;
    req_t r;
    s0_arvalid = 1'b0;
    s0_araddr  = '0;
    s0_arlen   = '0;
    forever begin
      @(negedge clk);
      acc = s0_arvalid && s0_arready;
      rs  = rst;
      @(posedge clk);
      #1;
      if (rs || acc) s0_arvalid = 1'b0;
      if (!rs && !s0_arvalid && rq0.size() > 0) begin
        r = rq0.pop_front();
        s0_araddr  = r.addr;
        s0_arlen   = r.len;
        s0_arvalid = 1'b1;
      end
    end
  end

  // Request agent, port 1
  initial begin : agent1
    logic acc, rs;
    req_t r;
    s1_arvalid = 1'b0;
    s1_araddr  = '0;
    s1_arlen   = '0;
    forever begin
      @(negedge clk);
      acc = s1_arvalid && s1_arready;
      rs  = rst;
      @(posedge clk);
      #1;
      if (rs || acc) s1_arvalid = 1'b0;
      if (!rs && !s1_arvalid && rq1.size() > 0) begin
        r = rq1.pop_front();
        s1_araddr  = r.addr;
        s1_arlen   = r.len;
        s1_arvalid = 1'b1;
      end
    end
  end

  // Memory: accepts AR a cycle after it appears, returns addr+4*beat
  initial begin : memory
    logic        av, har, hr, rs, active;
    logic [31:0] ba, baddr;
    int          bl, nb, b;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    active = 1'b0;
    baddr = '0;
    nb = 0;
    b = 0;
    forever begin
      @(negedge clk);
      av  = m_arvalid;
      har = m_arvalid && m_arready;
      hr  = m_rvalid && m_rready;
      rs  = rst;
      ba  = m_araddr;
      bl  = int'(m_arlen);
      @(posedge clk);
      #1;
      if (rs) begin
        active = 1'b0;
        m_arready = 1'b0;
      end else begin
        if (har) begin
          m_arready = 1'b0;
          baddr = ba;
          nb = (short_last >= 0) ? short_last + 1 : bl + 1;
          short_last = -1;
          b = 0;
          active = 1'b1;
        end else if (av && !m_arready) begin
          m_arready = 1'b1;
        end
        if (hr) begin
          b++;
          if (b == nb) active = 1'b0;
        end
      end
      m_rvalid = active;
      m_rdata  = active ? baddr + 32'(4 * b) : 32'h0;
      m_rlast  = active && (b == nb - 1);
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (s0_rvalid && s0_rready) begin
        if (bq0.size() == 0) chk("s0_extra_beat", 1, 0);
        else begin
          e = bq0.pop_front();
          chk("s0_rdata", s0_rdata, e.d);
          chk("s0_rlast", s0_rlast, e.l);
        end
        beats0++;
      end
      if (s1_rvalid && s1_rready) begin
        if (bq1.size() == 0) chk("s1_extra_beat", 1, 0);
        else begin
          e = bq1.pop_front();
          chk("s1_rdata", s1_rdata, e.d);
          chk("s1_rlast", s1_rlast, e.l);
        end
        beats1++;
      end
      if (s0_rvalid || s1_rvalid)
        chk("one_rvalid", s0_rvalid && s1_rvalid, 0);
      if (s0_arready || s1_arready)
        chk("one_arready", s0_arready && s1_arready, 0);
      if (m_arvalid && !prev_av)
        chk("ar_gap_ok", (cyc - last_rl) >= 2, 1);
      if (m_arvalid && m_arready) begin
        if (aq.size() == 0) chk("ar_extra", 1, 0);
        else begin
          chk("m_araddr", m_araddr, aq.pop_front());
          chk("grant_id", grant_id, gq.pop_front());
        end
      end
      if (m_rvalid && m_rready && m_rlast) last_rl = cyc;
      if (len_err) lerr_cnt++;
      prev_av = m_arvalid;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rq0.delete();
    rq1.delete();
    bq0.delete();
    bq1.delete();
    aq.delete();
    gq.delete();
    short_last = -1;
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    lerr_cnt = 0;
    beats0 = 0;
    beats1 = 0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = !busy && !s0_arvalid && !s1_arvalid &&
             rq0.size() == 0 && rq1.size() == 0 &&
             bq0.size() == 0 && bq1.size() == 0;
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_ar_left"}, aq.size(), 0);
  endtask

  task automatic wait_beats1(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (beats1 >= n);
    end
    if (!ok) chk("beats1_timeout", 0, 1);
  endtask

  task automatic wait_arvalid(input int p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? s0_arvalid : s1_arvalid;
    end
    if (!ok) chk("arvalid_timeout", 0, 1);
  endtask

  initial begin
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_m_araddr", m_araddr, 0);
    chk("rst_m_arlen", m_arlen, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_len_err", len_err, 0);

    // Reset mid-burst abandons it
    req(1, 32'h8000_0000, 7, -1);
    expect_ar(32'h8000_0000, 1'b1);
    wait_beats1(3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_arvalid", m_arvalid, 0);
    chk("midrst_m_rready", m_rready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s1_rvalid", s1_rvalid, 0);
    do_reset();

    // Single inst burst with latency checks
    req(0, 32'hBFC0_0000, 7, -1);
    expect_ar(32'hBFC0_0000, 1'b0);
    wait_arvalid(0);
    chk("c0_s0_arready", s0_arready, 1);
    chk("c0_s1_arready", s1_arready, 0);
    chk("c0_m_arvalid", m_arvalid, 0);
    @(negedge clk);
    chk("c1_m_arvalid", m_arvalid, 1);
    chk("c1_m_araddr", m_araddr, 32'hBFC0_0000);
    chk("c1_m_arlen", m_arlen, 7);
    chk("c1_busy", busy, 1);
    chk("c1_s0_arready", s0_arready, 0);
    wait_done("inst");
    chk("inst_beats0", beats0, 8);
    chk("inst_beats1", beats1, 0);
    chk("inst_len_err", lerr_cnt, 0);

    // Simultaneous requests: data first, then inst
    do_reset();
    req(0, 32'hBFC0_0040, 7, -1);
    req(1, 32'h8000_1000, 7, -1);
    expect_ar(32'h8000_1000, 1'b1);
    expect_ar(32'hBFC0_0040, 1'b0);
    wait_arvalid(1);
    chk("sim_s0_arvalid", s0_arvalid, 1);
    chk("sim_s1_arready", s1_arready, 1);
    chk("sim_s0_arready", s0_arready, 0);
    wait_done("sim");
    chk("sim_beats0", beats0, 8);
    chk("sim_beats1", beats1, 8);

    // Starvation guard: 1,1,1,1,0,1,1
    do_reset();
    req(0, 32'hBFC0_0100, 1, -1);
    for (int i = 0; i < 6; i++) begin
      req(1, 32'h8000_2000 + 32'(i * 256), 1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      expect_ar(32'h8000_2000 + 32'(i * 256), 1'b1);
    end
    expect_ar(32'hBFC0_0100, 1'b0);
    expect_ar(32'h8000_2400, 1'b1);
    expect_ar(32'h8000_2500, 1'b1);
    wait_done("starve");
    chk("starve_beats0", beats0, 2);
    chk("starve_beats1", beats1, 12);

    // Uncached single beat, then early rlast
    do_reset();
    req(1, 32'h8000_3000, 0, -1);
    expect_ar(32'h8000_3000, 1'b1);
    wait_done("unc");
    chk("unc_beats1", beats1, 1);
    chk("unc_len_err", lerr_cnt, 0);
    short_last = 1;
    req(1, 32'h8000_3100, 3, 2);
    expect_ar(32'h8000_3100, 1'b1);
    wait_done("short");
    chk("short_beats1", beats1, 3);
    chk("short_len_err", lerr_cnt, 1);
    chk("short_busy", busy, 0);

    // Back-pressure from data_cache mid-burst
    do_reset();
    req(1, 32'h8000_4000, 7, -1);
    expect_ar(32'h8000_4000, 1'b1);
    wait_beats1(3);
    @(posedge clk);
    #1;
    s1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_m_rready", m_rready, 0);
      chk("stall_s1_rvalid", s1_rvalid, 1);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    s1_rready = 1'b1;
    wait_done("stall");
    chk("stall_beats1", beats1, 8);
    chk("stall_len_err", lerr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
